instruction_encoder: RTL and testbench

Packs decoded RISC-V RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, immediate) back into 32-bit instruction words. This is the inverse of the instruction decoder. It is used by the program loader and self-test sequencer to build instruction-memory images on chip. Input and output both use valid/ready handshakes. A 2-entry output buffer absorbs back-pressure, and each emitted word is tagged with a sequential instruction-memory word address.

---
 rtl/instruction_encoder.sv | 175 +++++++++++++++++
 tb/tb_instruction_encoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// RV32I field packer: turns decoded fields back into instruction words, tags them with
// a wrapping word address and queues them in a 2-entry output buffer. Optional macro: IMM_RANGE_CHECK_EN.
module instruction_encoder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_immediate,
  input  logic                  addr_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instruction,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic                  out_error,
  output logic                  error_sticky
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid may not depend on ready, and the payload is held while valid && !ready.

  localparam logic [2:0] FMT_BAD = 3'd0;
  localparam logic [2:0] FMT_U   = 3'd1;
  localparam logic [2:0] FMT_J   = 3'd2;
  localparam logic [2:0] FMT_I   = 3'd3;
  localparam logic [2:0] FMT_SH  = 3'd4;
  localparam logic [2:0] FMT_S   = 3'd5;
  localparam logic [2:0] FMT_B   = 3'd6;
  localparam logic [2:0] FMT_R   = 3'd7;

  logic [2:0]            fmt;
  logic [31:0]           enc_word;
  logic                  enc_error;
  logic [31:0]           imm;
  logic [1:0]            count;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH-1:0] tag;
  logic [31:0]           skid_word;
  logic [ADDR_WIDTH-1:0] skid_addr;
  logic                  skid_error;

  assign imm = in_immediate;

  always_comb begin
    fmt = FMT_BAD;
    if (in_opcode[1:0] == 2'b11) begin
      case (in_opcode[6:2])
        5'b01101, 5'b00101:                 fmt = FMT_U;
        5'b11011:                           fmt = FMT_J;
        5'b00000, 5'b00011, 5'b11001,
        5'b11100:                           fmt = FMT_I;
        5'b00100: fmt = (in_funct3 == 3'b001 || in_funct3 == 3'b101) ? FMT_SH : FMT_I;
        5'b01000:                           fmt = FMT_S;
        5'b11000:                           fmt = FMT_B;
        5'b01100:                           fmt = FMT_R;
        default:                            fmt = FMT_BAD;
      endcase
    end
  end

  always_comb begin
    enc_word = NOP_WORD;
    case (fmt)
      FMT_U:  enc_word = {imm[31:12], in_rd, in_opcode};
      FMT_J:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, in_opcode};
      FMT_I:  enc_word = {imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_SH: enc_word = {in_funct7, imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S:  enc_word = {imm[11:5], in_rs2, in_rs1, in_funct3, imm[4:0], in_opcode};
      FMT_B:  enc_word = {imm[12], imm[10:5], in_rs2, in_rs1, in_funct3, imm[4:1], imm[11],
                          in_opcode};
      FMT_R:  enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default: enc_word = NOP_WORD;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic range_bad;

  // An immediate is representable when every bit above the field's sign bit copies it.
  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        range_bad = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      FMT_J:        range_bad = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      FMT_U:        range_bad = |imm[11:0];
      FMT_SH:       range_bad = |imm[31:5];
      default:      range_bad = 1'b0;
    endcase
  end

  assign enc_error = (fmt == FMT_BAD) || range_bad;
`else
  assign enc_error = (fmt == FMT_BAD);
`endif

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign tag       = addr_clear ? '0 : addr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt     <= '0;
      error_sticky <= 1'b0;
    end else begin
      if (addr_clear) begin
        addr_cnt     <= push ? ADDR_WIDTH'(1) : '0;
        error_sticky <= push && enc_error;
      end else if (push) begin
        addr_cnt     <= addr_cnt + 1'b1;
        error_sticky <= error_sticky || enc_error;
      end
    end
  end

  // The out_* registers are the FIFO head; the skid entry holds the second word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count           <= 2'd0;
      out_instruction <= '0;
      out_address     <= '0;
      out_error       <= 1'b0;
      skid_word       <= '0;
      skid_addr       <= '0;
      skid_error      <= 1'b0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            out_instruction <= enc_word;
            out_address     <= tag;
            out_error       <= enc_error;
            count           <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            out_instruction <= enc_word;
            out_address     <= tag;
            out_error       <= enc_error;
          end else if (push) begin
            skid_word  <= enc_word;
            skid_addr  <= tag;
            skid_error <= enc_error;
            count      <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            out_instruction <= skid_word;
            out_address     <= skid_addr;
            out_error       <= skid_error;
            count           <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: spec-level encoder model plus FIFO/address
// scoreboard checked every cycle, with hand-computed literal words pinning the model.
module tb_instruction_encoder;

  localparam int AW = 2;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RANGE = 1'b1;
`else
  localparam bit RANGE = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_immediate;
  logic          addr_clear;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instruction;
  logic [AW-1:0] out_address;
  logic          out_error;
  logic          error_sticky;

  instruction_encoder #(.ADDR_WIDTH(AW), .NOP_WORD(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_immediate(in_immediate),
    .addr_clear(addr_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_address(out_address),
    .out_error(out_error), .error_sticky(error_sticky)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard entry: {error, address, word}
  logic [32+AW:0] exp_q[$];
  logic [32+AW:0] m_last;
  logic [AW-1:0]  m_addr;
  logic           m_sticky;
  logic           last_acc;
  logic [32:0]    pin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoder model written from the field layout rules; returns {error, word}.
  function automatic logic [32:0] model_encode(input logic [6:0] opc, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w, o, d, s1, s2, f, sf7;
    int          s;
    logic        illegal, bad;
    s = $signed(imm);
    o = 32'(opc); d = 32'(rd) << 7; s1 = 32'(rs1) << 15; s2 = 32'(rs2) << 20;
    f = 32'(f3) << 12; sf7 = 32'(f7) << 25;
    w = 32'h0; illegal = 1'b0; bad = 1'b0;
    if (opc[1:0] != 2'b11) illegal = 1'b1;
    else begin
      case (opc[6:2])
        5'h0D, 5'h05: begin
          w = (imm & 32'hFFFFF000) | d | o;
          bad = (imm & 32'hFFF) != 0;
        end
        5'h1B: begin
          w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
          bad = imm[0] || s < -(1 << 20) || s > (1 << 20) - 1;
        end
        5'h00, 5'h03, 5'h04, 5'h19, 5'h1C: begin
          if (opc[6:2] == 5'h04 && (f3 == 3'd1 || f3 == 3'd5)) begin
            w = sf7 | ((imm & 32'h1F) << 20) | s1 | f | d | o;
            bad = imm > 32'd31;
          end else begin
            w = ((imm & 32'hFFF) << 20) | s1 | f | d | o;
            bad = s < -2048 || s > 2047;
          end
        end
        5'h08: begin
          w = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | f | ((imm & 32'h1F) << 7) | o;
          bad = s < -2048 || s > 2047;
        end
        5'h18: begin
          w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | f
            | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
          bad = imm[0] || s < -4096 || s > 4095;
        end
        5'h0C: w = sf7 | s2 | s1 | f | d | o;
        default: illegal = 1'b1;
      endcase
    end
    if (illegal) return {1'b1, 32'h00000013};
    return {bad && RANGE, w};
  endfunction

  // driver: one clock, advancing the model with what the DUT samples at this edge
  task automatic tick();
    logic        acc, pp;
    logic [32:0] e;
    logic [AW-1:0] t;
    acc = rst_n && in_valid && (exp_q.size() < 2);
    pp  = rst_n && out_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (pp) void'(exp_q.pop_front());
    if (acc) begin
      e = model_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_immediate);
      t = addr_clear ? '0 : m_addr;
      exp_q.push_back({e[32], t, e[31:0]});
      m_addr = t + 1'b1;
      m_sticky = addr_clear ? e[32] : (m_sticky || e[32]);
    end else if (addr_clear) begin
      m_addr = '0;
      m_sticky = 1'b0;
    end
    if (exp_q.size() != 0) m_last = exp_q[0];
    last_acc = acc;
    #1;
  endtask

  task automatic set_in(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm);
    in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_immediate = imm;
  endtask

  task automatic send(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm);
    set_in(opc, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 8 && !last_acc; i++) tick();
    chk("accept_timeout", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("out_instruction", out_instruction, m_last[31:0]);
        chk("out_address", 32'(out_address), 32'(m_last[32+AW-1:32]));
        chk("out_error", 32'(out_error), 32'(m_last[32+AW]));
        chk("error_sticky", 32'(error_sticky), 32'(m_sticky));
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; addr_clear = 1'b0; out_ready = 1'b1;
    set_in(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    exp_q.delete(); m_last = '0; m_addr = '0; m_sticky = 1'b0; last_acc = 1'b0;

    // model pinned to hand-encoded words
    pin = model_encode(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("pin_addi", pin[31:0], 32'h00500093);
    pin = model_encode(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC);
    chk("pin_sw", pin[31:0], 32'hFE21AE23);
    pin = model_encode(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("pin_add", pin[31:0], 32'h002081B3);
    pin = model_encode(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    chk("pin_beq", pin[31:0], 32'h00208463);
    pin = model_encode(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    chk("pin_lui", pin[31:0], 32'h123450B7);
    pin = model_encode(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    chk("pin_jal", pin[31:0], 32'h008000EF);
    pin = model_encode(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd3);
    chk("pin_srai", pin[31:0], 32'h40335293);

    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_instruction", out_instruction, 32'd0);
    chk("reset_error_sticky", 32'(error_sticky), 32'd0);
    #20 rst_n = 1'b1;
    tick();

    // ADDI, SW, ADD streaming with out_ready high
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("addi_word", out_instruction, 32'h00500093);
    chk("addi_addr", 32'(out_address), 32'd0);
    chk("addi_err", 32'(out_error), 32'd0);
    send(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC);
    chk("sw_word", out_instruction, 32'hFE21AE23);
    chk("sw_addr", 32'(out_address), 32'd1);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("add_word", out_instruction, 32'h002081B3);
    chk("add_addr", 32'(out_address), 32'd2);
    send(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    send(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd3);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    chk("beq_word", out_instruction, 32'h00208463);
    send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    chk("illegal_word", out_instruction, 32'h00000013);
    chk("illegal_err", 32'(out_error), 32'd1);
    chk("illegal_sticky", 32'(error_sticky), 32'd1);
    send(7'h12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    tick(); tick();

    // back-pressure: fill, refuse, hold head, then drain
    out_ready = 1'b0;
    set_in(7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // address wrap with ADDR_WIDTH=2, then clear coinciding with an accept
    addr_clear = 1'b1; tick(); addr_clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      chk("wrap_addr", 32'(out_address), 32'(i % 4));
    end
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    addr_clear = 1'b1;
    send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    addr_clear = 1'b0;
    chk("clear_addr", 32'(out_address), 32'd0);
    chk("clear_sticky", 32'(error_sticky), 32'd0);
    send(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    chk("after_clear_addr", 32'(out_address), 32'd1);
    tick();

    // out-of-range immediate, then reset with two words buffered
    out_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    chk("range_word", out_instruction, 32'h80000093);
    chk("range_err", 32'(out_error), 32'(RANGE));
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
    tick();
    rst_n = 1'b0;
    exp_q.delete(); m_last = '0; m_addr = '0; m_sticky = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_out_address", 32'(out_address), 32'd0);
    chk("midreset_out_instruction", out_instruction, 32'd0);
    tick();
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("post_reset_addr", 32'(out_address), 32'd0);
    chk("post_reset_word", out_instruction, 32'h00500093);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
